// File: rtl/pwm_pkg.sv
// pwm_pkg: sequencer state type and channel word constants shared by the PWM segment sequencer
package pwm_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, ARM, RUN, GAP, STOP, HALT} seq_state_t;
  localparam int PNUM_DIR_BIT = 31;
  localparam int PNUM_CNT_W = 24;
  localparam int ARM_TIMEOUT = 8;
endpackage

// File: rtl/seg_fifo.sv
// seg_fifo: synchronous segment FIFO with flush and occupancy count
module seg_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 64
) (
  input  logic                     Clk100m,
  input  logic                     Rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge Clk100m)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge Clk100m)
    if (Rst || flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/pwm_seg_sequencer.sv
// pwm_seg_sequencer: queues host motion segments and plays them back-to-back into one PWM channel
module pwm_seg_sequencer
  import pwm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP_CYC = 0
) (
  input  logic                     Clk100m,
  input  logic                     Rst,
  input  logic                     seg_wr,
  input  logic [31:0]              seg_freq,
  input  logic [31:0]              seg_pnum,
  input  logic                     run,
  input  logic                     abort,
  input  logic                     fault_clr,
  input  logic                     limit,
  input  logic                     pwm_state,
  output logic [31:0]              pwm_freq,
  output logic [31:0]              pwm_pnum,
  output logic                     pwm_pnump,
  output logic                     pwm_start,
  output logic                     pwm_stop,
  output logic                     seg_full,
  output logic [$clog2(DEPTH):0]   seg_level,
  output logic                     busy,
  output logic                     seg_done,
  output logic                     err_limit,
  output logic                     err_ovf
);
  seq_state_t state, state_n;
  logic [15:0] cnt;
  logic [63:0] head;
  logic state_q, fifo_empty, act, trip, pop, flush, leave_halt;
  assign act = state inside {LOAD, START, ARM, RUN, GAP};
  assign trip = !limit && state != HALT;
  assign pop = state == IDLE && run && !fifo_empty && !abort && !trip;
  assign flush = trip || (abort && (act || state == IDLE));
  assign leave_halt = state == HALT && state_n == IDLE;
  seg_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .Clk100m (Clk100m),
    .Rst     (Rst),
    .push    (seg_wr),
    .pop     (pop),
    .flush   (flush),
    .din     ({seg_freq, seg_pnum}),
    .dout    (head),
    .full    (seg_full),
    .empty   (fifo_empty),
    .level   (seg_level)
  );
  always_ff @(posedge Clk100m)
    state <= Rst ? IDLE : state_n;
  // RUN watches the registered busy flag so completion lands one cycle after the fall
  always_comb begin
    state_n = state;
    if (trip) state_n = HALT;
    else if (abort && act) state_n = STOP;
    else
      case (state)
        IDLE:    state_n = pop ? LOAD : IDLE;
        LOAD:    state_n = START;
        START:   state_n = ARM;
        ARM:     state_n = pwm_state ? RUN : cnt == 16'(ARM_TIMEOUT - 1) ? HALT : ARM;
        RUN:     state_n = state_q ? RUN : GAP_CYC > 0 ? GAP : IDLE;
        GAP:     state_n = cnt == 16'(GAP_CYC - 1) ? IDLE : GAP;
        STOP:    state_n = pwm_state ? STOP : IDLE;
        HALT:    state_n = fault_clr && limit ? IDLE : HALT;
        default: state_n = IDLE;
      endcase
  end
  always_comb begin
    busy = state != IDLE;
    pwm_pnump = state == LOAD;
    pwm_start = state == START;
    pwm_stop = act && abort && !trip && pwm_state;
    seg_done = state == RUN && !state_q && !abort && !trip;
  end
  always_ff @(posedge Clk100m)
    if (Rst) begin
      pwm_freq <= '0;
      pwm_pnum <= '0;
      cnt <= '0;
      state_q <= 1'b0;
      err_limit <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (pop) {pwm_freq, pwm_pnum} <= head;
      cnt <= state_n == state ? cnt + 16'd1 : '0;
      state_q <= pwm_state;
      err_limit <= !leave_halt && (err_limit || (state_n == HALT && state != HALT));
      err_ovf <= (err_ovf && !leave_halt) || (seg_wr && seg_full);
    end
endmodule

// File: tb/tb_pwm_seg_sequencer.sv
// tb_pwm_seg_sequencer: directed stimulus with a timestamp-based reference model and literal timing checks
module tb_pwm_seg_sequencer;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GAP0 = 0;
  localparam int GAP1 = 5;
  typedef enum {M_IDLE, M_SEG, M_STOP, M_HALT} mmode_t;
  logic Clk100m = 0, Rst = 1, seg_wr = 0, run = 0, abort = 0, fault_clr = 0, limit = 1;
  logic [31:0] seg_freq = 0, seg_pnum = 0;
  logic [31:0] f0, p0, f1, p1;
  logic pn0, st0, sp0, full0, busy0, dn0, el0, eo0;
  logic pn1, st1, sp1, full1, busy1, dn1, el1, eo1;
  logic [LW-1:0] lv0, lv1;
  logic ps0, ps1;
  int chan_len = 50, cc0 = 0, cc1 = 0;
  int checks = 0, passes = 0;
  assign ps0 = cc0 != 0;
  assign ps1 = cc1 != 0;
  always #5 Clk100m = ~Clk100m;
  pwm_seg_sequencer #(.DEPTH(DEPTH), .GAP_CYC(GAP0)) dut0 (
    .Clk100m(Clk100m), .Rst(Rst), .seg_wr(seg_wr), .seg_freq(seg_freq), .seg_pnum(seg_pnum),
    .run(run), .abort(abort), .fault_clr(fault_clr), .limit(limit), .pwm_state(ps0),
    .pwm_freq(f0), .pwm_pnum(p0), .pwm_pnump(pn0), .pwm_start(st0), .pwm_stop(sp0),
    .seg_full(full0), .seg_level(lv0), .busy(busy0), .seg_done(dn0), .err_limit(el0), .err_ovf(eo0)
  );
  pwm_seg_sequencer #(.DEPTH(DEPTH), .GAP_CYC(GAP1)) dut1 (
    .Clk100m(Clk100m), .Rst(Rst), .seg_wr(seg_wr), .seg_freq(seg_freq), .seg_pnum(seg_pnum),
    .run(run), .abort(abort), .fault_clr(fault_clr), .limit(limit), .pwm_state(ps1),
    .pwm_freq(f1), .pwm_pnum(p1), .pwm_pnump(pn1), .pwm_start(st1), .pwm_stop(sp1),
    .seg_full(full1), .seg_level(lv1), .busy(busy1), .seg_done(dn1), .err_limit(el1), .err_ovf(eo1)
  );
  // channel models: busy for chan_len cycles after a start, never busy when chan_len is 0
  always @(posedge Clk100m) begin
    cc0 <= (!limit || sp0) ? 0 : (st0 && chan_len != 0) ? chan_len : (cc0 != 0) ? cc0 - 1 : 0;
    cc1 <= (!limit || sp1) ? 0 : (st1 && chan_len != 0) ? chan_len : (cc1 != 0) ? cc1 - 1 : 0;
  end
  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction
  logic [63:0] q[$];
  logic [31:0] mf, mp;
  bit me_l, me_o, hi, mvalid, ps_prev;
  mmode_t mm = M_IDLE;
  int cyc = 0, pop_c = -100, fall_c = -1, rel_c = -1;
  int st_c[$], fl_c[$];
  logic [31:0] st_p[$];
  int done_n = 0, stop_n = 0, done1_n = 0, dc0 = -1, gp0 = -1, dc1 = -1, gp1 = -1;
  always @(negedge Clk100m) begin
    bit trip, flushed;
    int sz;
    logic [127:0] act_v, exp_v;
    cyc++;
    trip = !limit && mm != M_HALT;
    act_v = {f0, p0, pn0, st0, sp0, full0, lv0, busy0, dn0, el0, eo0};
    exp_v = {mf, mp, mm == M_SEG && cyc == pop_c + 1, mm == M_SEG && cyc == pop_c + 2,
             mm == M_SEG && abort && !trip && ps0, q.size() == DEPTH, LW'(q.size()),
             mm != M_IDLE, mm == M_SEG && fall_c >= 0 && cyc == fall_c + 1 && !abort && !trip, me_l, me_o};
    if (mvalid) chk($sformatf("outputs@%0d", cyc), act_v, exp_v);
    if (st0) begin st_c.push_back(cyc); st_p.push_back(p0); end
    if (ps_prev && !ps0) fl_c.push_back(cyc);
    ps_prev = ps0;
    if (dn0) begin done_n++; dc0 = cyc; end
    if (sp0) stop_n++;
    if (pn0 && dc0 >= 0) begin gp0 = cyc - dc0; dc0 = -1; end
    if (dn1) begin done1_n++; dc1 = cyc; end
    if (pn1 && dc1 >= 0) begin gp1 = cyc - dc1; dc1 = -1; end
    sz = q.size();
    flushed = 0;
    if (Rst) begin
      q.delete(); mf = 0; mp = 0; me_l = 0; me_o = 0; mm = M_IDLE; pop_c = -100; fall_c = -1; mvalid = 1;
    end else begin
      if (trip) begin q.delete(); flushed = 1; me_l = 1; mm = M_HALT; end
      else case (mm)
        M_HALT: if (fault_clr && limit) begin mm = M_IDLE; me_l = 0; me_o = 0; end
        M_STOP: if (!ps0) mm = M_IDLE;
        M_IDLE:
          if (abort) begin q.delete(); flushed = 1; end
          else if (run && sz > 0) begin
            {mf, mp} = q.pop_front(); pop_c = cyc; hi = 0; fall_c = -1; rel_c = -1; mm = M_SEG;
          end
        M_SEG:
          if (abort) begin q.delete(); flushed = 1; mm = M_STOP; end
          else if (!hi) begin
            if (cyc >= pop_c + 3) begin
              if (ps0) hi = 1;
              else if (cyc == pop_c + 10) begin me_l = 1; mm = M_HALT; end
            end
          end else if (fall_c < 0) begin
            if (!ps0) begin fall_c = cyc; rel_c = cyc + 2 + GAP0; end
          end else if (cyc + 1 == rel_c) mm = M_IDLE;
      endcase
      if (seg_wr) begin
        if (sz == DEPTH) me_o = 1;
        else if (!flushed) q.push_back({seg_freq, seg_pnum});
      end
    end
  end
  task automatic step();
    @(posedge Clk100m);
    #1;
  endtask
  task automatic do_reset();
    run = 0; abort = 0; fault_clr = 0; limit = 1; seg_wr = 0;
    Rst = 1;
    step();
    Rst = 0;
    st_c.delete(); st_p.delete(); fl_c.delete();
    done_n = 0; stop_n = 0; done1_n = 0; dc0 = -1; gp0 = -1; dc1 = -1; gp1 = -1;
  endtask
  task automatic push(input logic [31:0] f, input logic [31:0] p);
    seg_wr = 1; seg_freq = f; seg_pnum = p;
    step();
    seg_wr = 0;
  endtask
  task automatic wait_done(input int n, input int lim);
    int k = 0;
    while (done_n < n && k < lim) begin step(); k++; end
    chk("done_count", done_n, n);
  endtask
  initial begin
    int c_run, s0, d0, k;
    step();
    do_reset();
    chk("rst_level", lv0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_freq", f0, 0);
    chk("rst_pnum", p0, 0);
    chk("rst_flags", {el0, eo0, full0}, 0);
    chk("rst_strobes", {pn0, st0, sp0, dn0}, 0);
    chan_len = 50;
    push(10, 4); push(20, 5); push(30, 6);
    chk("level_three", lv0, 3);
    run = 1;
    c_run = cyc + 1;
    wait_done(3, 400);
    run = 0;
    chk("n_starts", st_c.size(), 3);
    if (st_c.size() == 3 && fl_c.size() >= 2) begin
      chk("issue_latency", st_c[0] - c_run, 2);
      chk("pnum_order0", st_p[0], 4);
      chk("pnum_order1", st_p[1], 5);
      chk("pnum_order2", st_p[2], 6);
      chk("restart_gap1", st_c[1] - fl_c[0], 4);
      chk("restart_gap2", st_c[2] - fl_c[1], 4);
    end
    do_reset();
    chan_len = 10;
    push(1, 7); push(2, 8);
    run = 1;
    k = 0;
    while ((done_n < 2 || done1_n < 2) && k < 200) begin step(); k++; end
    run = 0;
    chk("gap_done_count1", done1_n, 2);
    chk("gap0_done_to_load", gp0, 2);
    chk("gap5_done_to_load", gp1, 7);
    do_reset();
    for (int i = 0; i < 9; i++) push(32'(i + 1), 32'(i + 100));
    chk("ovf_full", full0, 1);
    chk("ovf_err", eo0, 1);
    chk("ovf_level", lv0, 8);
    do_reset();
    chan_len = 50;
    run = 1;
    push(11, 1); push(12, 2); push(13, 3); push(14, 4);
    chk("pushpop_level", lv0, 3);
    repeat (15) step();
    d0 = done_n; s0 = stop_n;
    abort = 1;
    #1;
    chk("abort_stop", sp0, 1);
    step();
    abort = 0;
    chk("abort_flush", lv0, 0);
    chk("abort_busy", busy0, 1);
    k = 0;
    while (busy0 && k < 10) begin step(); k++; end
    chk("abort_idle", busy0, 0);
    chk("abort_no_done", done_n, d0);
    chk("abort_one_stop", stop_n, s0 + 1);
    run = 0;
    do_reset();
    run = 1;
    push(100, 1); push(200, 2);
    repeat (15) step();
    limit = 0;
    step();
    chk("limit_err", el0, 1);
    chk("limit_flush", lv0, 0);
    chk("limit_halt", busy0, 1);
    fault_clr = 1;
    step();
    fault_clr = 0;
    chk("halt_hold", busy0, 1);
    limit = 1;
    step();
    fault_clr = 1;
    step();
    fault_clr = 0;
    chk("halt_exit", busy0, 0);
    chk("halt_err_clr", el0, 0);
    run = 0;
    do_reset();
    chan_len = 0;
    push(5, 5);
    run = 1;
    step();
    repeat (9) step();
    chk("arm_wait_err", el0, 0);
    chk("arm_wait_busy", busy0, 1);
    step();
    chk("arm_timeout_err", el0, 1);
    chk("arm_timeout_halt", busy0, 1);
    run = 0;
    fault_clr = 1;
    step();
    fault_clr = 0;
    chk("timeout_exit", busy0, 0);
    do_reset();
    chan_len = 50;
    run = 1;
    push(7, 9);
    repeat (15) step();
    run = 0;
    s0 = stop_n;
    Rst = 1;
    step();
    Rst = 0;
    chk("midrst_busy", busy0, 0);
    chk("midrst_freq", f0, 0);
    chk("midrst_pnum", p0, 0);
    chk("midrst_no_stop", stop_n, s0);
    repeat (60) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pwm_seg_sequencer.md
# pwm_seg_sequencer

Segment sequencer for one PWM pulse-generator channel. It queues motion segments (frequency word plus direction/pulse-count word) written by the host bus and plays them back-to-back into the channel. For each segment it drives the channel's parameter-load, start and stop strobes and watches the channel's busy state. It sits between the AHB register file and the per-axis PWM generator, and it handles abort, emergency-limit halt and an optional inter-segment dwell.

## Interface
- DEPTH, 8: segment FIFO depth; power of two, 2..64.
- GAP_CYC, 0: idle cycles inserted between consecutive segments (16-bit range).
- Clk100m  in  1  system clock, 100 MHz.
- Rst  in  1  reset; synchronous, active-high.
- seg_wr  in  1  push {seg_freq, seg_pnum} into the FIFO.
- seg_freq  in  32  period word; passed through verbatim.
- seg_pnum  in  32  bit31 = direction, [23:0] = count field; passed through verbatim.
- run  in  1  level; while high, queued segments are issued.
- abort  in  1  pulse; stop the current segment and flush the FIFO.
- fault_clr  in  1  pulse; leave HALT.
- limit  in  1  emergency limit, active-low (0 = tripped).
- pwm_state  in  1  channel busy flag.
- pwm_freq  out  32  registered freq word to the channel.
- pwm_pnum  out  32  registered pnum word to the channel.
- pwm_pnump  out  1  one-cycle parameter-load strobe.
- pwm_start  out  1  one-cycle start strobe.
- pwm_stop  out  1  one-cycle stop strobe.
- seg_full  out  1  FIFO full.
- seg_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM is not in IDLE.
- seg_done  out  1  one-cycle pulse when a segment completes normally.
- err_limit  out  1  sticky; the limit tripped while the block was active.
- err_ovf  out  1  sticky; a push was attempted while the FIFO was full.

## Operation
- FIFO push rules:
  - A push while full is dropped and sets err_ovf.
  - Push and pop in the same cycle are both honoured, and the level is unchanged.
- FSM states: IDLE, LOAD, START, ARM, RUN, GAP, STOP, HALT.
- IDLE: when run=1, the FIFO is non-empty and limit=1, pop the head entry into pwm_freq/pwm_pnum and go to LOAD.
- LOAD: drive pwm_pnump=1 for one cycle, then go to START.
- START: drive pwm_start=1 for one cycle, then go to ARM.
- ARM: wait for pwm_state=1, then go to RUN. After 8 cycles without it, set err_limit and go to HALT.
- RUN: when pwm_state falls to 0, pulse seg_done. Then go to GAP if GAP_CYC>0, otherwise to IDLE.
- GAP: count GAP_CYC cycles, then go to IDLE. A new segment can be issued on the cycle after GAP ends.
- abort while in LOAD, START, ARM, RUN or GAP:
  - Flush the FIFO (level becomes 0).
  - Pulse pwm_stop if pwm_state=1.
  - Go to STOP, which waits for pwm_state=0, then goes to IDLE. seg_done is not pulsed.
- abort in IDLE flushes the FIFO only.
- limit=0 in any state except HALT:
  - Flush the FIFO, set err_limit, go to HALT. This takes priority over abort and over normal transitions in the same cycle.
  - No pwm_stop is issued; the channel stops itself on the limit.
- HALT: leave to IDLE only on fault_clr=1 with limit=1. fault_clr also clears err_limit and err_ovf.
- Clearing run takes effect only at IDLE; a segment already issued runs to completion.
- pwm_freq/pwm_pnum hold their values between pops.

## Timing
- Reset values:
  - All strobes, busy, seg_done, err_limit and err_ovf are 0.
  - pwm_freq and pwm_pnum are 0.
  - FIFO is empty, seg_level=0, FSM is in IDLE.
- Issue latency: with run=1 and the FIFO non-empty in IDLE at cycle N, the pop occurs at N, pwm_pnump=1 at N+1, and pwm_start=1 at N+2.
- A push at cycle N is visible in seg_level at N+1 and can be popped from N+1.
- Back-to-back segments with GAP_CYC=0: pwm_state falls at cycle M, seg_done=1 at M+1, the next pop at M+2 (IDLE), and the next pwm_start at M+4.
- Rst asserted mid-segment returns the block to its reset state on the next edge; no pwm_stop is issued.

## Structure
- Shared package pwm_pkg holds:
  - the state enum;
  - the constants PNUM_DIR_BIT=31, PNUM_CNT_W=24, ARM_TIMEOUT=8.
- Sub-module seg_fifo: synchronous FIFO, width 64, depth DEPTH, with full/empty/level outputs and a flush input. The FSM and error flags live in the top level.

## Test plan
- Three segments pushed (freq 10/20/30, pnum 4/5/6), run=1, channel model busy for 50 cycles each -> three seg_done pulses, pwm_pnum values in order 4, 5, 6, pwm_start 4 cycles after each prior falling edge of pwm_state.
- GAP_CYC=5 with two segments -> 5 more cycles between the seg_done pulse and the second pop than with GAP_CYC=0.
- DEPTH=8: nine pushes -> seg_full=1, err_ovf=1, seg_level=8.
- abort during RUN with 3 segments queued -> one pwm_stop pulse, seg_level=0, no seg_done, IDLE after pwm_state=0.
- limit=0 during RUN -> err_limit=1, HALT, FIFO flushed. fault_clr with limit=0 -> stays in HALT. fault_clr with limit=1 -> IDLE, err_limit=0.
- Channel model never raises pwm_state -> ARM times out after 8 cycles, err_limit=1, HALT.
